// File: rtl/sprite_pkg.sv
// sprite_pkg: shared state encoding, pixel field widths and index sizing for the sprite scheduler
package sprite_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    LAUNCH = 3'd2,
    SERVE  = 3'd3,
    DONE   = 3'd4
  } state_e;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  // One spare code so a scan pointer can sit one past the last engine.
  function automatic int idx_w(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/sprite_scheduler_if.sv
// sprite_scheduler_if: engine-side streams and VGA write port
//   master (scheduler): takes engine masks/strobes/pixels, drives spr_en and vga_*
//   slave  (engines/adapter side): the mirror image
interface sprite_scheduler_if #(
  parameter int N_SPR = 6
);
  import sprite_pkg::*;
  logic [N_SPR-1:0]     spr_active;
  logic [N_SPR-1:0]     spr_plot;
  logic [N_SPR-1:0]     spr_finish;
  logic [N_SPR-1:0]     spr_en;
  logic [X_W*N_SPR-1:0] spr_x;
  logic [Y_W*N_SPR-1:0] spr_y;
  logic [C_W*N_SPR-1:0] spr_colour;
  logic [X_W-1:0]       vga_x;
  logic [Y_W-1:0]       vga_y;
  logic [C_W-1:0]       vga_colour;
  logic                 vga_plot;
  modport master (
    input  spr_active, spr_plot, spr_finish, spr_x, spr_y, spr_colour,
    output spr_en, vga_x, vga_y, vga_colour, vga_plot
  );
  modport slave (
    output spr_active, spr_plot, spr_finish, spr_x, spr_y, spr_colour,
    input  spr_en, vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: free-running 0..FRAME_DIV-1 counter with a one-cycle tick on the last count
//   clk, resetn (sync, active-low) in; tick_o out
module frame_tick_gen #(
  parameter int FRAME_DIV = 833333
) (
  input  logic clk,
  input  logic resetn,
  output logic tick_o
);
  localparam int CW = $clog2(FRAME_DIV);
  logic [CW-1:0] count_q;
  assign tick_o = count_q == CW'(FRAME_DIV - 1);
  always_ff @(posedge clk)
    count_q <= (!resetn || tick_o) ? '0 : count_q + 1'b1;
endmodule

// File: rtl/sprite_scheduler.sv
// sprite_scheduler: per-frame round of sprite engines sharing one VGA write port
//   clk, resetn (sync, active-low); bus: engine streams in, spr_en + muxed vga_* out
//   busy / frame_done / overrun (sticky) / timeout_err (sticky) status out
module sprite_scheduler
  import sprite_pkg::*;
#(
  parameter int N_SPR     = 6,
  parameter int FRAME_DIV = 833333,
  parameter int TIMEOUT   = 4096
) (
  input  logic               clk,
  input  logic               resetn,
  sprite_scheduler_if.master bus,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun,
  output logic               timeout_err
);
  localparam int IDX_W = idx_w(N_SPR);
  localparam int WD_W  = $clog2(TIMEOUT + 1);
  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, grant_q, grant_d, sel;
  logic [WD_W-1:0]  wd_q, wd_d;
  logic             overrun_q, timeout_q, tick, found, fin, expired;
  logic [N_SPR-1:0] en;
  logic [X_W-1:0]   vx;
  logic [Y_W-1:0]   vy;
  logic [C_W-1:0]   vc;
  logic             vp;
  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick_o (tick)
  );
  // Descending scan so the lowest qualifying index is the one left standing.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = N_SPR - 1; i >= 0; i--)
      if (bus.spr_active[i] && IDX_W'(i) >= ptr_q) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
  end
  // Everything routed by grant: launch pulse, finish sense and the pixel mux.
  always_comb begin
    fin = 1'b0;
    en  = '0;
    vx  = '0;
    vy  = '0;
    vc  = '0;
    vp  = 1'b0;
    for (int i = 0; i < N_SPR; i++)
      if (grant_q == IDX_W'(i)) begin
        fin   = bus.spr_finish[i];
        en[i] = state_q == LAUNCH;
        if (state_q == SERVE) begin
          vx = bus.spr_x[i*X_W +: X_W];
          vy = bus.spr_y[i*Y_W +: Y_W];
          vc = bus.spr_colour[i*C_W +: C_W];
          vp = bus.spr_plot[i];
        end
      end
  end
  assign expired = wd_q == WD_W'(TIMEOUT - 1);
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    case (state_q)
      IDLE: if (tick) begin
        state_d = SELECT;
        ptr_d   = '0;
      end
      SELECT: begin
        grant_d = found ? sel : grant_q;
        state_d = found ? LAUNCH : DONE;
      end
      LAUNCH: begin
        wd_d    = '0;
        state_d = SERVE;
      end
      SERVE: if (fin || expired) begin
        ptr_d   = grant_q + 1'b1;
        state_d = SELECT;
      end else
        wd_d = wd_q + 1'b1;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      wd_q      <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      wd_q      <= wd_d;
      overrun_q <= overrun_q | (tick && state_q != IDLE);
      // A finish on the expiry cycle wins, so no error is flagged then.
      timeout_q <= timeout_q | (state_q == SERVE && !fin && expired);
    end
  assign bus.spr_en     = en;
  assign bus.vga_x      = vx;
  assign bus.vga_y      = vy;
  assign bus.vga_colour = vc;
  assign bus.vga_plot   = vp;
  assign busy           = state_q != IDLE;
  assign frame_done     = state_q == DONE;
  assign overrun        = overrun_q;
  assign timeout_err    = timeout_q;
endmodule

// File: tb/tb_sprite_scheduler.sv
// tb_sprite_scheduler: table vectors, hand sequences and random frames against an event-level schedule model
module tb_sprite_scheduler;
  localparam int N = 4, FD = 64, TMO = 32, NC = 260, NEVER = 1000;
  logic clk = 1'b0, resetn = 1'b0;
  logic busy, frame_done, overrun, timeout_err;
  sprite_scheduler_if #(.N_SPR(N)) bus();
  sprite_scheduler #(.N_SPR(N), .FRAME_DIV(FD), .TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .busy(busy), .frame_done(frame_done), .overrun(overrun), .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0]       mask;
    logic [3:0][10:0] k;
    logic [3:0][7:0]  off;
    logic [7:0]       done;
    logic             ovr;
    logic             to;
  } vec_t;
  vec_t tbl[5];
  int total = 0, bad = 0, cyc = 0;
  int k_cfg[N], cnt[N], first_en[N], first_done;
  int en0_t[$];
  logic [3:0] mask_cfg, en_prev;
  logic [3:0] exp_en[NC];
  logic exp_done[NC], exp_busy[NC];
  int exp_g[NC], ovr_from, to_from;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, a, e);
    end
  endtask

  // Schedule derived from the timing rules: each engine costs SELECT+LAUNCH,
  // then min(K+1, TIMEOUT) SERVE cycles; a frame ends with one DONE cycle.
  function automatic void build();
    int t, s, e, d, dn, nt;
    for (int c = 0; c < NC; c++) begin
      exp_en[c] = '0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0; exp_g[c] = -1;
    end
    ovr_from = 10 * NEVER;
    to_from  = 10 * NEVER;
    t = FD - 1;
    while (t < NC) begin
      s = t + 1;
      for (int i = 0; i < N; i++)
        if (mask_cfg[i]) begin
          e = s + 1;
          d = (k_cfg[i] + 1 > TMO) ? TMO : k_cfg[i] + 1;
          if (k_cfg[i] + 1 > TMO && e + d + 1 < to_from) to_from = e + d + 1;
          if (e < NC) exp_en[e][i] = 1'b1;
          for (int j = e + 1; j <= e + d && j < NC; j++) exp_g[j] = i;
          s = e + d + 1;
        end
      dn = s + 1;
      if (dn < NC) exp_done[dn] = 1'b1;
      for (int j = t + 1; j <= dn && j < NC; j++) exp_busy[j] = 1'b1;
      nt = t + FD;
      while (nt <= dn) begin
        if (nt + 1 < ovr_from) ovr_from = nt + 1;
        nt += FD;
      end
      t = nt;
    end
  endfunction

  task automatic restart();
    cyc = 0;
    en_prev = '0;
    first_done = -1;
    for (int i = 0; i < N; i++) begin cnt[i] = 0; first_en[i] = -1; end
    en0_t.delete();
    build();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    restart();
  endtask

  // One clock: behavioural engines + random pixel data, then mid-cycle check.
  task automatic step();
    logic [26:0] a, e;
    int g;
    for (int i = 0; i < N; i++) begin
      if (en_prev[i]) cnt[i] = 1;
      else if (cnt[i] == k_cfg[i] + 1) cnt[i] = 0;
      else if (cnt[i] != 0) cnt[i]++;
      bus.spr_finish[i] = cnt[i] == k_cfg[i] + 1;
    end
    bus.spr_active = mask_cfg;
    bus.spr_plot   = 4'($urandom);
    bus.spr_x      = $urandom;
    bus.spr_y      = 28'($urandom);
    bus.spr_colour = 12'($urandom);
    @(negedge clk);
    if (cyc < NC) begin
      g = exp_g[cyc] < 0 ? 0 : exp_g[cyc];
      e = {exp_en[cyc], exp_done[cyc], exp_busy[cyc], cyc >= ovr_from, cyc >= to_from, 19'b0};
      if (exp_g[cyc] >= 0)
        e[18:0] = {bus.spr_plot[g], bus.spr_x[g*8 +: 8], bus.spr_y[g*7 +: 7], bus.spr_colour[g*3 +: 3]};
      a = {bus.spr_en, frame_done, busy, overrun, timeout_err,
           bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour};
      chk("cycle", 32'(a), 32'(e));
    end
    en_prev = bus.spr_en;
    for (int i = 0; i < N; i++) if (bus.spr_en[i] && first_en[i] < 0) first_en[i] = cyc;
    if (frame_done && first_done < 0) first_done = cyc;
    if (bus.spr_en[0]) en0_t.push_back(cyc);
    @(posedge clk);
    #1 cyc++;
  endtask

  initial begin
    bus.spr_active = '0; bus.spr_plot = '0; bus.spr_finish = '0;
    bus.spr_x = '0; bus.spr_y = '0; bus.spr_colour = '0;
    tbl[0] = '{4'hF, {4{11'd10}}, {8'd41, 8'd28, 8'd15, 8'd2}, 8'd54, 1'b0, 1'b0};
    tbl[1] = '{4'hA, {4{11'd10}}, {8'd15, 8'd255, 8'd2, 8'd255}, 8'd28, 1'b0, 1'b0};
    tbl[2] = '{4'h0, {4{11'd10}}, {4{8'd255}}, 8'd2, 1'b0, 1'b0};
    tbl[3] = '{4'hF, {11'd10, 11'd1000, 11'd10, 11'd10}, {8'd62, 8'd28, 8'd15, 8'd2}, 8'd75, 1'b1, 1'b1};
    tbl[4] = '{4'hF, {4{11'd20}}, {8'd71, 8'd48, 8'd25, 8'd2}, 8'd94, 1'b1, 1'b0};
    mask_cfg = '0;
    for (int i = 0; i < N; i++) k_cfg[i] = 10;
    resetn = 1'b0;
    @(posedge clk);
    #1 chk("reset_state", {busy, frame_done, overrun, timeout_err, bus.spr_en, bus.vga_plot,
                           bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    for (int t = 0; t < 5; t++) begin
      mask_cfg = tbl[t].mask;
      for (int i = 0; i < N; i++) k_cfg[i] = int'(tbl[t].k[i]);
      do_reset();
      repeat (NC) step();
      for (int i = 0; i < N; i++)
        chk($sformatf("tbl%0d_en%0d", t, i), first_en[i],
            tbl[t].off[i] == 8'd255 ? -1 : FD - 1 + int'(tbl[t].off[i]));
      chk($sformatf("tbl%0d_done", t), first_done, FD - 1 + int'(tbl[t].done));
      chk($sformatf("tbl%0d_overrun", t), overrun, tbl[t].ovr);
      chk($sformatf("tbl%0d_timeout", t), timeout_err, tbl[t].to);
    end
    // Overrunning frame finishes, then the next frame waits for the tick after it.
    mask_cfg = 4'hF;
    for (int i = 0; i < N; i++) k_cfg[i] = 20;
    do_reset();
    repeat (NC) step();
    chk("overrun_next_frame", en0_t.size() > 1 ? en0_t[1] : -1, 3 * FD - 1 + 2);
    // One-cycle reset while engine 1 is being served.
    for (int i = 0; i < N; i++) k_cfg[i] = 10;
    do_reset();
    repeat (82) step();
    chk("mid_serve_grant1", bus.vga_plot, bus.spr_plot[1]);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    restart();
    chk("mid_reset_idle", {busy, frame_done, overrun, timeout_err, bus.spr_en, bus.vga_plot,
                           bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    repeat (160) step();
    chk("restart_en0", en0_t.size() > 0 ? en0_t[0] : -1, FD + 1);
    for (int r = 0; r < 8; r++) begin
      mask_cfg = 4'($urandom);
      for (int i = 0; i < N; i++)
        k_cfg[i] = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 40));
      do_reset();
      repeat (NC) step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
